// File: rtl/core_input_buf.sv
// Per-core block input buffer: four {ctx,seq} slots of 16 words each, filled by
// the realign side and replayed to the SHA-512 core as a 16-word stream.
`ifndef BLK_OP_MSB
`define BLK_OP_MSB 3
`endif

module core_input_buf #(
    parameter int WIDTH    = 64,
    parameter int N_SLOTS  = 4,
    parameter int BLK_OP_W = `BLK_OP_MSB + 1
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [WIDTH-1:0]    din,
    input  logic                wr_ctx,
    input  logic                wr_seq,
    input  logic [BLK_OP_W-1:0] wr_blk_op,
    output logic [N_SLOTS-1:0]  slot_full,
    input  logic                rd_start,
    input  logic [1:0]          rd_slot,
    output logic                rd_busy,
    output logic [WIDTH-1:0]    dout,
    output logic                dout_valid,
    output logic                dout_last,
    output logic [BLK_OP_W-1:0] dout_blk_op,
    output logic                dout_ctx,
    output logic                dout_seq,
    output logic                err
);

    localparam int DEPTH = N_SLOTS * 16;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [1:0]           cur_q;
    logic [N_SLOTS-1:0]   slot_full_q, slot_full_d;
    logic [BLK_OP_W-1:0]  blk_op_q [N_SLOTS];
    logic [WIDTH-1:0]     mem [DEPTH];

    logic [1:0]           wr_slot;
    logic                 wr_ok;
    logic                 wr_bad;
    logic                 start_ok;
    logic                 start_bad;
    logic                 rd_en;
    logic                 rd_done;

    assign wr_slot = {wr_ctx, wr_seq};
    // Full check uses the pre-edge flag, so a slot clearing this edge still rejects.
    assign wr_ok   = wr_en & ~slot_full_q[wr_slot];
    assign wr_bad  = wr_en &  slot_full_q[wr_slot];

    assign slot_full = slot_full_q;
    assign rd_busy   = (state_q == READ);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        rd_en     = 1'b0;
        rd_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    if (slot_full_q[rd_slot]) begin
                        start_ok = 1'b1;
                        state_d  = READ;
                        cnt_d    = 4'd0;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            READ: begin
                rd_en = 1'b1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    rd_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A write can only set a slot that is empty and the clear targets the busy
    // (full) slot, so set and clear never collide on the same index.
    always_comb begin
        slot_full_d = slot_full_q;
        if (wr_ok && wr_addr == 4'd15)
            slot_full_d[wr_slot] = 1'b1;
        if (rd_done)
            slot_full_d[cur_q] = 1'b0;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cur_q       <= 2'd0;
            slot_full_q <= '0;
            err         <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
            dout_blk_op <= '0;
            dout_ctx    <= 1'b0;
            dout_seq    <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++)
                blk_op_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_full_q <= slot_full_d;
            dout_valid  <= rd_en;
            dout_last   <= rd_done;
            if (wr_bad || start_bad)
                err <= 1'b1;
            if (wr_ok && wr_addr == 4'd15)
                blk_op_q[wr_slot] <= wr_blk_op;
            if (start_ok) begin
                cur_q       <= rd_slot;
                dout_blk_op <= blk_op_q[rd_slot];
                dout_ctx    <= rd_slot[1];
                dout_seq    <= rd_slot[0];
            end
            if (rd_en)
                dout <= mem[{cur_q, cnt_q}];
        end
    end

    // Storage is left uninitialised; reads and writes in one cycle hit different slots.
    always_ff @(posedge CLK) begin
        if (wr_ok)
            mem[{wr_slot, wr_addr}] <= din;
    end

endmodule
